// File: rtl/enc_rr_128_7.sv
`default_nettype none
// ============================================================================
//  Module      : enc_rr_128_7
//  Description : Registered N-to-W request encoder with a valid/ack handshake.
//                Reduces a multi-hot request vector to one binary index plus
//                a one-hot echo, and holds the grant until it is acknowledged.
//                Optional macro ENC_RR_PRIORITY_EN selects round-robin
//                arbitration; without it the lowest set index always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_rr_128_7 #(
    parameter int N = 128,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]   state_q,  state_d;
    logic         valid_q,  valid_d;
    logic [W-1:0] idx_q,    idx_d;
    logic [N-1:0] onehot_q, onehot_d;

    // Scan start position; constant zero in the fixed-priority build.
    logic [W-1:0] w_ptr;

`ifdef ENC_RR_PRIORITY_EN
    logic [W-1:0] ptr_q, ptr_d;
    assign w_ptr = ptr_q;
`else
    assign w_ptr = '0;
`endif

    // Winner search signals.
    logic [N-1:0] w_mask;
    logic [N-1:0] w_req_hi;
    logic         w_hi_found;
    logic [W-1:0] w_hi_idx;
    logic         w_any_found;
    logic [W-1:0] w_any_idx;
    logic [W-1:0] w_win_idx;
    logic         w_req_any;

    // Keep only requests at or above the pointer for the first scan.
    assign w_mask    = ~((N'(1) << w_ptr) - N'(1));
    assign w_req_hi  = req & w_mask;
    assign w_req_any = |req;

    // Lowest set bit of the masked vector (upper segment of the ring).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_hi_found = 1'b1;
                w_hi_idx   = W'(i);
            end
        end
    end

    // Lowest set bit of the full vector, used when the upper segment is empty.
    always_comb begin
        w_any_found = 1'b0;
        w_any_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any_found = 1'b1;
                w_any_idx   = W'(i);
            end
        end
    end

    // Upper segment wins when non-empty; otherwise wrap to the bottom.
    assign w_win_idx = w_hi_found ? w_hi_idx : (w_any_found ? w_any_idx : '0);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
`ifdef ENC_RR_PRIORITY_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
`ifdef ENC_RR_PRIORITY_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Next-state: IDLE leaves on any request, GRANT leaves on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (w_req_any) state_d = c_ST_GRANT;
            c_ST_GRANT: if (ack)       state_d = c_ST_IDLE;
            default:                   state_d = c_ST_IDLE;
        endcase
    end

    // Output/datapath next values: load winner in IDLE, freeze until ack in GRANT.
    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
`ifdef ENC_RR_PRIORITY_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (w_req_any) begin
                    valid_d  = 1'b1;
                    idx_d    = w_win_idx;
                    onehot_d = N'(1) << w_win_idx;
                end else begin
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    onehot_d = '0;
                end
            end
            c_ST_GRANT: begin
                if (ack) begin
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    onehot_d = '0;
`ifdef ENC_RR_PRIORITY_EN
                    // Natural W-bit wrap: N-1 rolls over to 0.
                    ptr_d    = idx_q + W'(1);
`endif
                end
            end
            default: begin
                valid_d  = 1'b0;
                idx_d    = '0;
                onehot_d = '0;
            end
        endcase
    end

    assign grant_valid  = valid_q;
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign busy         = (state_q == c_ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_enc_rr_128_7.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_rr_128_7
//  Description : Self-checking bench for enc_rr_128_7: directed scenarios
//                plus randomized traffic against a ring-scan reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_rr_128_7;

    localparam int N = 128;
    localparam int W = 7;
`ifdef ENC_RR_PRIORITY_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         ack;
    logic         grant_valid;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_onehot;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit m_valid;
    int m_idx;
    int m_ptr;

    enc_rr_128_7 #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // First set bit found walking the ring upward from p.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Advance model and DUT by one clock edge; outputs sampled 1 time unit later.
    task automatic cyc();
        if (rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0;
        end else if (!m_valid) begin
            if (req != '0) begin
                m_valid = 1;
                m_idx   = pick(req, RR ? m_ptr : 0);
            end
        end else if (ack) begin
            m_valid = 0;
            if (RR) m_ptr = (m_idx + 1) % N;
            m_idx = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = '1; ack = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (grant_valid !== 1'b0 || grant_idx !== '0 || grant_onehot !== '0 || busy !== 1'b0)
                $display("FAIL reset_outputs cycle %0d: valid=%b idx=%0d onehot=%h busy=%b, required all 0",
                         i, grant_valid, grant_idx, grant_onehot, busy);
            else n_pass++;
        end
        rst = 0;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 7'd0 || grant_onehot !== bit_of(0) || busy !== 1'b1)
            $display("FAIL reset_first_grant: valid=%b idx=%0d onehot=%h busy=%b, required 1/0/1/1",
                     grant_valid, grant_idx, grant_onehot, busy);
        else n_pass++;
        ack = 1;
        cyc();
        ack = 0; req = '0;
        n_checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== '0 || busy !== 1'b0)
            $display("FAIL reset_ack_clear: valid=%b onehot=%h busy=%b, required 0",
                     grant_valid, grant_onehot, busy);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int seq [4];
        if (RR) seq = '{3, 70, 127, 3};
        else    seq = '{3, 3, 3, 3};
        req = bit_of(3) | bit_of(70) | bit_of(127);
        ack = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++;
            if (i % 2 == 0) begin
                if (grant_valid !== 1'b1 || grant_idx !== W'(seq[i/2]) || grant_onehot !== bit_of(seq[i/2]))
                    $display("FAIL rotation_grant %0d: valid=%b idx=%0d, required valid=1 idx=%0d",
                             i/2, grant_valid, grant_idx, seq[i/2]);
                else n_pass++;
            end else begin
                if (grant_valid !== 1'b0 || grant_idx !== '0 || grant_onehot !== '0)
                    $display("FAIL rotation_gap %0d: valid=%b idx=%0d, required valid=0 idx=0",
                             i/2, grant_valid, grant_idx);
                else n_pass++;
            end
        end
        ack = 0; req = '0;
    endtask

    task automatic test_wrap();
        req = bit_of(127); ack = 0;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 7'd127)
            $display("FAIL wrap_grant127: valid=%b idx=%0d, required 1/127", grant_valid, grant_idx);
        else n_pass++;
        ack = 1; req = bit_of(5) | bit_of(127);
        cyc();
        ack = 0;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 7'd5 || grant_onehot !== bit_of(5))
            $display("FAIL wrap_next: valid=%b idx=%0d, required 1/5", grant_valid, grant_idx);
        else n_pass++;
        ack = 1; req = '0;
        cyc();
        ack = 0;
    endtask

    task automatic test_sticky();
        int exp_after;
        req = bit_of(40); ack = 0;
        cyc();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 7'd40 || grant_onehot !== bit_of(40) || busy !== 1'b1)
                $display("FAIL sticky_hold cycle %0d: valid=%b idx=%0d busy=%b, required 1/40/1",
                         i, grant_valid, grant_idx, busy);
            else n_pass++;
        end
        ack = 1;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b0 || grant_idx !== '0 || grant_onehot !== '0 || busy !== 1'b0)
            $display("FAIL sticky_release: valid=%b idx=%0d busy=%b, required 0",
                     grant_valid, grant_idx, busy);
        else n_pass++;
        // Ack while idle with no requests must not disturb anything.
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_checks++;
            if (grant_valid !== 1'b0 || grant_onehot !== '0 || busy !== 1'b0)
                $display("FAIL idle_ack cycle %0d: valid=%b busy=%b, required 0", i, grant_valid, busy);
            else n_pass++;
        end
        // Pointer sits just past 40 in round-robin, so 50 beats 10 there.
        exp_after = RR ? 50 : 10;
        ack = 0; req = bit_of(10) | bit_of(50);
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== W'(exp_after))
            $display("FAIL idle_ack_ptr: idx=%0d, required %0d", grant_idx, exp_after);
        else n_pass++;
        ack = 1; req = '0;
        cyc();
        ack = 0;
    endtask

    task automatic test_reset_mid();
        req = bit_of(90); ack = 0;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 7'd90)
            $display("FAIL rstmid_grant90: valid=%b idx=%0d, required 1/90", grant_valid, grant_idx);
        else n_pass++;
        rst = 1; ack = 1; req = bit_of(10) | bit_of(90);
        cyc();
        n_checks++;
        if (grant_valid !== 1'b0 || grant_idx !== '0 || grant_onehot !== '0 || busy !== 1'b0)
            $display("FAIL rstmid_clear: valid=%b idx=%0d busy=%b, required 0", grant_valid, grant_idx, busy);
        else n_pass++;
        rst = 0; ack = 0;
        cyc();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 7'd10 || grant_onehot !== bit_of(10))
            $display("FAIL rstmid_next: valid=%b idx=%0d, required 1/10", grant_valid, grant_idx);
        else n_pass++;
        ack = 1; req = '0;
        cyc();
        ack = 0;
    endtask

    task automatic test_random();
        int fails_here = 0;
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = bit_of($urandom_range(0, N - 1));
                2: req = r;
                default: req = r & {$urandom, $urandom, $urandom, $urandom}
                                 & {$urandom, $urandom, $urandom, $urandom};
            endcase
            ack = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 49) == 0);
            cyc();
            n_checks++;
            if (grant_valid !== m_valid || grant_idx !== W'(m_idx) || busy !== m_valid ||
                grant_onehot !== (m_valid ? bit_of(m_idx) : '0)) begin
                if (fails_here < 10)
                    $display("FAIL random cycle %0d: valid=%b idx=%0d busy=%b, required valid=%b idx=%0d",
                             c, grant_valid, grant_idx, busy, m_valid, m_idx);
                fails_here++;
            end else n_pass++;
        end
        rst = 0; ack = 0; req = '0;
    endtask

    initial begin
        rst = 1; req = '0; ack = 0;
        m_valid = 0; m_idx = 0; m_ptr = 0;
        test_reset();
        test_rotation();
        test_wrap();
        test_sticky();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
